mmio_hub: RTL and testbench

//  Parametrised memory-mapped IO hub between the core data port and RAM/peripherals.

---
 rtl/mmio_pkg.sv | 37 +++
 rtl/spi_flash_reader.sv | 128 ++++++++++++
 rtl/mmio_hub.sv | 124 ++++++++++++
 tb/tb_mmio_hub.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO hub: register offsets, flash FSM states,
// SPI-flash command bytes, status bit positions and a byte-lane merge helper.
package mmio_pkg;

  localparam logic [2:0] REG_LED    = 3'd0;
  localparam logic [2:0] REG_GPIO   = 3'd1;
  localparam logic [2:0] REG_FADDR  = 3'd2;
  localparam logic [2:0] REG_FDATA  = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;
  localparam logic [7:0] FLASH_CMD_FAST = 8'h0B;

  localparam int ST_BUSY = 0;
  localparam int ST_OVR  = 1;
  localparam int ST_DONE = 2;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_CMD,
    FS_ADDR,
    FS_DUMMY,
    FS_DATA,
    FS_GAP
  } flash_state_e;

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_flash_reader.sv
// SPI mode-0 flash read engine: CMD, 24-bit address, optional dummy byte, data, gap.
// Define FLASH_FASTREAD_EN to issue 0x0B with an 8-clock dummy phase instead of 0x03.
module spi_flash_reader
  import mmio_pkg::*;
#(
  parameter int SPI_CLK_DIV = 2,
  parameter int READ_BYTES  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [23:0] addr,
  output logic        busy,
  output logic        done_pulse,
  output logic [31:0] data,
  output logic        spi_clk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

`ifdef FLASH_FASTREAD_EN
  localparam logic [7:0] CMD_BYTE  = FLASH_CMD_FAST;
  localparam bit         HAS_DUMMY = 1'b1;
`else
  localparam logic [7:0] CMD_BYTE  = FLASH_CMD_READ;
  localparam bit         HAS_DUMMY = 1'b0;
`endif

  localparam int DW = (SPI_CLK_DIV > 1) ? $clog2(SPI_CLK_DIV) : 1;

  flash_state_e state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic          ph;
  logic [4:0]    bit_cnt;
  logic [31:0]   tx_sr, rx_sr;
  logic          sclk_q;
  logic          tick, fall_tick, phase_end;

  // bit_cnt reload value (bits in phase minus one) for the phase being entered
  function automatic logic [4:0] phase_last(input flash_state_e s);
    case (s)
      FS_ADDR:  return 5'd23;
      FS_DUMMY: return 5'd7;
      FS_DATA:  return 5'(8*READ_BYTES-1);
      default:  return 5'd0;
    endcase
  endfunction

  // Bytes arrive MSB-first with byte 0 highest in rx_sr; FDATA is little-endian.
  function automatic logic [31:0] byte_order(input logic [31:0] rx);
    logic [31:0] r;
    int src;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      src = (k < READ_BYTES) ? (READ_BYTES - 1 - k) : 0;
      if (k < READ_BYTES) r[8*k +: 8] = rx[8*src +: 8];
    end
    return r;
  endfunction

  assign tick      = (div_cnt == DW'(SPI_CLK_DIV-1));
  assign fall_tick = tick & ph;
  assign phase_end = fall_tick & (bit_cnt == 5'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= FS_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FS_IDLE:  if (start)     state_nxt = FS_CMD;
      FS_CMD:   if (phase_end) state_nxt = FS_ADDR;
      FS_ADDR:  if (phase_end) state_nxt = HAS_DUMMY ? FS_DUMMY : FS_DATA;
      FS_DUMMY: if (phase_end) state_nxt = FS_DATA;
      FS_DATA:  if (phase_end) state_nxt = FS_GAP;
      FS_GAP:   if (phase_end) state_nxt = FS_IDLE;
      default:                 state_nxt = FS_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != FS_IDLE);
    spi_cs_n   = (state == FS_IDLE) || (state == FS_GAP);
    done_pulse = (state == FS_DATA) && phase_end;
  end

  // Divider and shifters: spi_clk stays low through GAP while the divider still times it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
      ph      <= 1'b0;
      sclk_q  <= 1'b0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
    end else if (state == FS_IDLE) begin
      div_cnt <= '0;
      ph      <= 1'b0;
      sclk_q  <= 1'b0;
      if (start) begin
        tx_sr   <= {CMD_BYTE, addr};
        rx_sr   <= '0;
        bit_cnt <= 5'd7;
      end
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        ph     <= ~ph;
        sclk_q <= ~ph && (state != FS_GAP);
        if (!ph) begin
          if (state == FS_DATA) rx_sr <= {rx_sr[30:0], spi_miso};
        end else begin
          tx_sr <= {tx_sr[30:0], 1'b0};
          if (bit_cnt != 5'd0) bit_cnt <= bit_cnt - 1'b1;
          else                 bit_cnt <= phase_last(state_nxt);
        end
      end
    end
  end

  assign spi_clk  = sclk_q;
  assign spi_mosi = tx_sr[31];
  assign data     = byte_order(rx_sr);

endmodule

// File: rtl/mmio_hub.sv
// Memory-mapped IO hub: IO page decode, LED/GPIO/flash/status registers and read mux.
// FLASH_FASTREAD_EN (see spi_flash_reader) switches the flash engine to fast-read.
module mmio_hub
  import mmio_pkg::*;
#(
  parameter int IO_PAGE_BIT    = 23,
  parameter int LED_W          = 6,
  parameter bit LED_ACTIVE_LOW = 1'b1,
  parameter int GPIO_W         = 8,
  parameter int SPI_CLK_DIV    = 2,
  parameter int READ_BYTES     = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              wen,
  input  logic              ren,
  input  logic [3:0]        byte_enable,
  input  logic [31:0]       ram_rdata,
  output logic              ram_we,
  output logic [31:0]       rdata,
  output logic [LED_W-1:0]  io_led,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              spi_clk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              busy
);

  logic              io_sel, io_wr, io_rd;
  logic [2:0]        reg_sel;
  logic [LED_W-1:0]  led_q;
  logic [GPIO_W-1:0] gpio_q;
  logic [31:0]       fdata_q, io_rdata_q, io_rd_val, status_v;
  logic [31:0]       led_wr, gpio_wr;
  logic              done_q, ovr_q, io_sel_q;
  logic              fl_start, fl_busy, fl_done;
  logic [31:0]       fl_data;
  logic              unused_bits;

  assign io_sel   = addr[IO_PAGE_BIT];
  assign reg_sel  = addr[4:2];
  assign io_wr    = wen & io_sel;
  assign io_rd    = ren & io_sel;
  assign ram_we   = wen & ~io_sel;
  assign fl_start = io_wr && (reg_sel == REG_FADDR) && !fl_busy;

  assign led_wr  = merge_be(32'(led_q), wdata, byte_enable);
  assign gpio_wr = merge_be(32'(gpio_q), wdata, byte_enable);
  assign unused_bits = ^{addr, led_wr, gpio_wr};

  spi_flash_reader #(
    .SPI_CLK_DIV (SPI_CLK_DIV),
    .READ_BYTES  (READ_BYTES)
  ) u_flash (
    .clk        (clk),
    .resetn     (resetn),
    .start      (fl_start),
    .addr       (wdata[23:0]),
    .busy       (fl_busy),
    .done_pulse (fl_done),
    .data       (fl_data),
    .spi_clk    (spi_clk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso)
  );

  always_comb begin
    status_v          = '0;
    status_v[ST_BUSY] = fl_busy;
    status_v[ST_OVR]  = ovr_q;
    status_v[ST_DONE] = done_q;
  end

  always_comb begin
    io_rd_val = '0;
    case (reg_sel)
      REG_LED:    io_rd_val = 32'(led_q);
      REG_GPIO:   io_rd_val = 32'(gpio_q);
      REG_FDATA:  io_rdata_val_fdata: io_rd_val = fdata_q;
      REG_STATUS: io_rd_val = status_v;
      default:    io_rd_val = '0;
    endcase
  end

  // Register bank; a completing transfer beats a same-cycle clearing read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q   <= '0;
      gpio_q  <= '0;
      fdata_q <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (io_wr && reg_sel == REG_LED)  led_q  <= led_wr[LED_W-1:0];
      if (io_wr && reg_sel == REG_GPIO) gpio_q <= gpio_wr[GPIO_W-1:0];
      if (fl_done) fdata_q <= fl_data;
      if (fl_done)                              done_q <= 1'b1;
      else if (io_rd && reg_sel == REG_FDATA)   done_q <= 1'b0;
      if (io_wr && reg_sel == REG_FADDR && fl_busy) ovr_q <= 1'b1;
      else if (io_rd && reg_sel == REG_STATUS)      ovr_q <= 1'b0;
    end
  end

  // io_sel_q resets high so rdata reads as zero before the first access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      io_sel_q   <= 1'b1;
      io_rdata_q <= '0;
    end else if (ren) begin
      io_sel_q   <= io_sel;
      io_rdata_q <= io_rd_val;
    end
  end

  assign rdata    = io_sel_q ? io_rdata_q : ram_rdata;
  assign io_led   = LED_ACTIVE_LOW ? ~led_q : led_q;
  assign gpio_out = gpio_q;
  assign busy     = fl_busy;

endmodule

// File: tb/tb_mmio_hub.sv
// Scoreboard bench for mmio_hub: reads and flash MOSI bytes are checked by monitors
// against queued expectations; a behavioural SPI flash answers reads.
module tb_mmio_hub;

`ifdef FLASH_FASTREAD_EN
  localparam int         DUM   = 8;
  localparam logic [7:0] CMD_B = 8'h0B;
`else
  localparam int         DUM   = 0;
  localparam logic [7:0] CMD_B = 8'h03;
`endif

  localparam logic [31:0] A_LED    = 32'h0080_0000;
  localparam logic [31:0] A_GPIO   = 32'h0080_0004;
  localparam logic [31:0] A_FADDR  = 32'h0080_0008;
  localparam logic [31:0] A_FDATA  = 32'h0080_000C;
  localparam logic [31:0] A_STATUS = 32'h0080_0010;
  localparam logic [31:0] A_UNMAP  = 32'h0080_0014;

  logic        clk = 1'b0, resetn = 1'b0;
  logic [31:0] addr = '0, wdata = '0, ram_rdata = '0;
  logic        wen = 1'b0, ren = 1'b0, spi_miso = 1'b0;
  logic [3:0]  byte_enable = '0;
  logic        ram_we, spi_clk, spi_cs_n, spi_mosi, busy;
  logic [31:0] rdata;
  logic [5:0]  io_led;
  logic [7:0]  gpio_out;

  int total = 0, bad = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic [7:0]  mosi_q[$];
  logic        ren_d = 1'b0;
  int          act_cnt = 0, base;
  int          bitn = 0;
  logic [7:0]  msr = '0;
  logic [7:0]  resp[4];

  mmio_hub dut (
    .clk(clk), .resetn(resetn), .addr(addr), .wdata(wdata), .wen(wen), .ren(ren),
    .byte_enable(byte_enable), .ram_rdata(ram_rdata), .ram_we(ram_we), .rdata(rdata),
    .io_led(io_led), .gpio_out(gpio_out), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  // Read-data monitor: one pop per issued read, checked mid-cycle after the capture edge.
  always @(posedge clk) ren_d <= ren;
  always @(negedge clk) begin
    if (ren_d) begin
      if (exp_q.size() == 0) chk("rd_unexpected", rdata, 32'hDEAD_0000);
      else chk(nm_q.pop_front(), rdata, exp_q.pop_front());
    end
  end

  // Flash model: capture MOSI on rising spi_clk, check command/address bytes.
  always @(posedge spi_clk or negedge spi_cs_n) begin
    if (!spi_clk) begin
      bitn = 0;
      msr  = '0;
    end else begin
      msr = {msr[6:0], spi_mosi};
      bitn++;
      if (bitn % 8 == 0 && bitn <= 32) begin
        if (mosi_q.size() == 0) chk("mosi_unexpected", {24'd0, msr}, 32'h0000_0100);
        else chk("mosi_byte", {24'd0, msr}, {24'd0, mosi_q.pop_front()});
      end
    end
  end

  // MISO presented on the falling edge so it is stable at the next rising edge.
  always @(negedge spi_clk or negedge spi_cs_n) begin
    int idx;
    idx = bitn - 32 - DUM;
    if (!spi_cs_n && idx >= 0 && idx < 32) spi_miso = resp[idx/8][7 - idx%8];
    else spi_miso = 1'b0;
  end

  always @(posedge clk) if (resetn && !spi_cs_n) act_cnt++;

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; wdata = d; byte_enable = be; wen = 1'b1;
    @(posedge clk); #1 wen = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    addr = a; ren = 1'b1;
    exp_q.push_back(e); nm_q.push_back(n);
    @(posedge clk); #1 ren = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && busy; i++) @(posedge clk);
    #1 chk("busy_drop", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    resp[0] = 8'hDE; resp[1] = 8'hAD; resp[2] = 8'hBE; resp[3] = 8'hEF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led",   {26'd0, io_led}, 32'h3F);
    chk("rst_cs_n",  {31'd0, spi_cs_n}, 32'd1);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_sclk",  {31'd0, spi_clk}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    rd(A_LED, 32'd0, "led_rst_read");

    wr(A_LED, 32'h15, 4'b0001);
    chk("led_write", {26'd0, io_led}, 32'h2A);
    wr(A_LED, 32'h3F, 4'b0000);
    chk("led_be0", {26'd0, io_led}, 32'h2A);
    rd(A_LED, 32'h15, "led_read");

    wr(A_GPIO, 32'hA5, 4'b1111);
    chk("gpio_out", {24'd0, gpio_out}, 32'hA5);
    rd(A_GPIO, 32'hA5, "gpio_read");
    addr = A_UNMAP; wdata = 32'hFFFF_FFFF; byte_enable = 4'hF; wen = 1'b1;
    #1 chk("io_ram_we", {31'd0, ram_we}, 32'd0);
    @(posedge clk); #1 wen = 1'b0;
    rd(A_UNMAP, 32'd0, "unmapped_read");
    rd(A_LED, 32'h15, "led_after_unmap");

    addr = 32'h0000_0100; wen = 1'b1;
    #1 chk("ram_we", {31'd0, ram_we}, 32'd1);
    @(posedge clk); #1 wen = 1'b0;
    ram_rdata = 32'hCAFE_F00D;
    rd(32'h0000_0100, 32'hCAFE_F00D, "ram_read");

    // flash read with an overlapping start request
    mosi_q.push_back(CMD_B); mosi_q.push_back(8'h00);
    mosi_q.push_back(8'h01); mosi_q.push_back(8'h00);
    base = act_cnt;
    wr(A_FADDR, 32'h0000_0100, 4'hF);
    chk("busy_set", {31'd0, busy}, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    wr(A_FADDR, 32'h0012_3456, 4'hF);
    rd(A_FDATA, 32'd0, "fdata_while_busy");
    wait_idle();
    chk("active_cycles", act_cnt - base, 4 * (64 + DUM));
    rd(A_STATUS, 32'h6, "status_done_ovr");
    rd(A_STATUS, 32'h4, "status_ovr_clr");
    rd(A_FDATA, 32'hEFBE_ADDE, "fdata");
    rd(A_STATUS, 32'h0, "status_done_clr");

    // async reset in the address phase
    mosi_q.push_back(CMD_B);
    wr(A_FADDR, 32'h0000_0100, 4'hF);
    for (int i = 0; i < 500 && bitn < 12; i++) @(posedge clk);
    chk("addr_phase_reached", {31'd0, bitn >= 12}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("mid_rst_sclk", {31'd0, spi_clk}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_led",  {26'd0, io_led}, 32'h3F);
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;

    resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h33; resp[3] = 8'h44;
    mosi_q.push_back(CMD_B); mosi_q.push_back(8'hAB);
    mosi_q.push_back(8'hCD); mosi_q.push_back(8'hEF);
    base = act_cnt;
    wr(A_FADDR, 32'h00AB_CDEF, 4'hF);
    wait_idle();
    chk("active_cycles_2", act_cnt - base, 4 * (64 + DUM));
    rd(A_FDATA, 32'h4433_2211, "fdata_2");
    rd(A_STATUS, 32'h0, "status_after_fdata");

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size() + mosi_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
